// File: rtl/serial_slave.sv
// Responder end of a single-wire bidirectional serial link: receives 32-bit request
// frames LSB first, forwards the data byte to a local sink and answers with an OK/FAIL frame.
module serial_slave #(
    parameter logic [7:0] SLAVE_ADDR  = 8'h01,
    parameter logic [7:0] START       = 8'hAA,
    parameter logic [7:0] MASTER_ADDR = 8'h00,
    parameter logic [7:0] OK          = 8'h01,
    parameter logic [7:0] FAIL        = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        serial,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic [7:0] err_count
);

    typedef enum logic {LISTEN, RESP} state_t;

    state_t      state;
    logic [31:0] sr;
    logic [31:0] tx;
    logic [4:0]  cnt;
    logic        match;
    logic        chk_ok;

    function automatic logic [31:0] make_frame(input logic [7:0] hi, input logic [7:0] lo);
        return {START, hi, lo, hi ^ lo};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decode the registered shift register; bit0 of the frame sits in sr[0].
    assign match  = (sr[31:24] == START) && (sr[23:16] == SLAVE_ADDR);
    assign chk_ok = (sr[7:0] == (sr[23:16] ^ sr[15:8]));

    // Line is only driven while responding; otherwise the master or the pull owns it.
    assign serial = (state == RESP) ? tx[cnt] : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LISTEN;
            sr        <= '0;
            cnt       <= '0;
            tx        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            err_count <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                LISTEN: begin
                    if (match) begin
                        state <= RESP;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        if (chk_ok && rx_ready) begin
                            rx_data  <= sr[15:8];
                            rx_valid <= 1'b1;
                            tx       <= make_frame(MASTER_ADDR, OK);
                        end else begin
                            tx <= make_frame(MASTER_ADDR, FAIL);
                            if (!chk_ok)
                                err_count <= sat_inc(err_count);
                        end
                    end else begin
                        sr <= {serial, sr[31:1]};
                    end
                end
                RESP: begin
                    if (cnt == 5'd31) begin
                        state <= LISTEN;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        sr    <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= LISTEN;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_slave.sv
// Bench for serial_slave: master model on a pulled-down shared line, scoreboard of
// expected responses and sink bytes, rx_valid pulse monitor.
module tb_serial_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_ready;
    logic       m_oe;
    logic       m_bit;
    wire        serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic [7:0] err_count;

    assign serial = m_oe ? m_bit : 1'bz;
    pulldown (serial);

    always #5 clk = ~clk;

    serial_slave dut (
        .clk(clk),
        .reset(reset),
        .serial(serial),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .busy(busy),
        .err_count(err_count)
    );

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int dbl = 0;
    logic prev_v = 1'b0;

    logic [31:0] exp_resp_q[$];
    logic [7:0]  exp_data_q[$];
    logic [7:0]  m_err;
    logic [7:0]  m_data;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            pulses++;
            if (prev_v === 1'b1) dbl++;
        end
        prev_v = rx_valid;
    end

    task automatic drive_frame(input logic [31:0] f);
        for (int i = 0; i < 32; i++) begin
            m_oe  = 1'b1;
            m_bit = f[i];
            @(posedge clk);
            #1;
        end
        m_oe = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic [7:0] addr, input logic [7:0] data,
                             input logic [7:0] chk, input logic rdy);
        logic [31:0] got;
        logic [31:0] exp;
        logic        hit;
        logic [7:0]  exp_d;
        int          p0;
        rx_ready = rdy;
        p0 = pulses;
        hit = 1'b0;
        if (addr == 8'h01) begin
            if (chk == (addr ^ data) && rdy) begin
                exp_resp_q.push_back(32'hAA000101);
                exp_data_q.push_back(data);
                m_data = data;
                hit = 1'b1;
            end else begin
                exp_resp_q.push_back(32'hAA000000);
                if (chk != (addr ^ data))
                    m_err = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
            end
        end else begin
            exp_resp_q.push_back(32'h0);
        end
        drive_frame({8'hAA, addr, data, chk});
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s turnaround busy: got %b want 0", name, busy);
        end
        for (int j = 0; j < 32; j++) begin
            @(posedge clk);
            #1;
            got[j] = serial;
            if (j == 0) begin
                tests++;
                if (busy !== (addr == 8'h01)) begin
                    fails++;
                    $display("FAIL %s busy in response: got %b want %b", name, busy, addr == 8'h01);
                end
            end
        end
        exp = exp_resp_q.pop_front();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s response: got %h want %h", name, got, exp);
        end
        tests++;
        if ((pulses - p0) != (hit ? 1 : 0)) begin
            fails++;
            $display("FAIL %s rx_valid pulses: got %0d want %0d", name, pulses - p0, hit ? 1 : 0);
        end
        if (exp_data_q.size() > 0) begin
            exp_d = exp_data_q.pop_front();
            tests++;
            if (rx_data !== exp_d) begin
                fails++;
                $display("FAIL %s rx_data: got %h want %h", name, rx_data, exp_d);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || rx_data !== m_data || err_count !== m_err) begin
            fails++;
            $display("FAIL %s after frame busy/rx_data/err: got %b/%h/%h want 0/%h/%h",
                     name, busy, rx_data, err_count, m_data, m_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_err = 8'h00;
        m_data = 8'h00;
        tests++;
        if (busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00 || err_count !== 8'h00 || serial !== 1'b0) begin
            fails++;
            $display("FAIL reset state: busy=%b vld=%b data=%h err=%h line=%b want 0", busy, rx_valid,
                     rx_data, err_count, serial);
        end
    endtask

    task automatic test_good();
        run_frame("good", 8'h01, 8'h5A, 8'h5B, 1'b1);
    endtask

    task automatic test_bad_chk();
        run_frame("bad_chk", 8'h01, 8'h5A, 8'h00, 1'b1);
        tests++;
        if (err_count !== 8'h01) begin
            fails++;
            $display("FAIL bad_chk err_count: got %h want 01", err_count);
        end
    endtask

    task automatic test_wrong_addr();
        run_frame("wrong_addr", 8'h02, 8'h5A, 8'h5B, 1'b1);
    endtask

    task automatic test_not_ready();
        run_frame("not_ready", 8'h01, 8'h5A, 8'h5B, 1'b0);
        rx_ready = 1'b1;
    endtask

    task automatic test_reset_mid_resp();
        drive_frame({8'hAA, 8'h01, 8'h3C, 8'h3D});
        for (int j = 0; j < 11; j++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_err = 8'h00;
        m_data = 8'h00;
        tests++;
        if (busy !== 1'b0 || serial !== 1'b0 || rx_data !== 8'h00 || err_count !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid_resp: busy=%b line=%b data=%h err=%h want 0", busy, serial,
                     rx_data, err_count);
        end
        run_frame("after_reset", 8'h01, 8'hC3, 8'hC2, 1'b1);
    endtask

    task automatic test_back_to_back();
        int p0;
        for (int k = 0; k < 256; k++)
            run_frame("sat", 8'h01, 8'h5A, 8'h00, 1'b1);
        tests++;
        if (err_count !== 8'hFF) begin
            fails++;
            $display("FAIL err_count saturation: got %h want ff", err_count);
        end
        p0 = pulses;
        run_frame("b2b_1", 8'h01, 8'h11, 8'h10, 1'b1);
        run_frame("b2b_2", 8'h01, 8'h22, 8'h23, 1'b1);
        tests++;
        if ((pulses - p0) != 2 || dbl != 0) begin
            fails++;
            $display("FAIL back_to_back pulses/double: got %0d/%0d want 2/0", pulses - p0, dbl);
        end
    endtask

    initial begin
        m_oe = 1'b0;
        m_bit = 1'b0;
        rx_ready = 1'b1;
        m_err = 8'h00;
        m_data = 8'h00;
        test_reset();
        test_good();
        test_bad_chk();
        test_wrong_addr();
        test_not_ready();
        test_reset_mid_resp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
